// File: rtl/canny_pkg.sv
// ---------------------------------------------------------------------------
// canny_pkg
// Shared types and constants for the Canny front-end line buffering.
//   state_e    : sequencing state of the three-line buffer controller
//   NBANK      : number of line RAMs (one-hot write bank width)
//   FILL_LINES : complete lines that must be stored before output starts
// ---------------------------------------------------------------------------
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int NBANK      = 3;
  localparam int FILL_LINES = 2;

endpackage

// File: rtl/lb_bank_rot.sv
// ---------------------------------------------------------------------------
// lb_bank_rot
// One-hot write-bank rotator with a matching newest-line index.
// Ports:
//   clk, rst_b : pixel clock, asynchronous active-low reset
//   clear      : return to bank 0 (wins over advance)
//   advance    : step to the next bank (line end)
//   bank       : one-hot write bank, 001 -> 010 -> 100 -> 001
//   tap_sel    : index 0..NBANK-1 of the bank currently being written
// ---------------------------------------------------------------------------
module lb_bank_rot
  import canny_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic             advance,
  output logic [NBANK-1:0] bank,
  output logic [1:0]       tap_sel
);

  localparam logic [NBANK-1:0] BANK0   = {{(NBANK-1){1'b0}}, 1'b1};
  localparam logic [1:0]       TAP_MAX = 2'(NBANK - 1);

  logic [NBANK-1:0] bank_q, bank_d;
  logic [1:0]       tap_q, tap_d;

  always_comb begin
    bank_d = bank_q;
    tap_d  = tap_q;
    if (clear) begin
      bank_d = BANK0;
      tap_d  = '0;
    end else if (advance) begin
      bank_d = {bank_q[NBANK-2:0], bank_q[NBANK-1]};
      tap_d  = (tap_q == TAP_MAX) ? 2'd0 : tap_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bank_q <= BANK0;
      tap_q  <= '0;
    end else begin
      bank_q <= bank_d;
      tap_q  <= tap_d;
    end
  end

  assign bank    = bank_q;
  assign tap_sel = tap_q;

endmodule

// File: rtl/line3_ctrl.sv
// ---------------------------------------------------------------------------
// line3_ctrl
// Sequencing controller for the three-line buffer in the Canny front end.
// It turns sensor vvalid/hvalid into line-RAM write/read strobes and
// addresses, rotates the write bank at every line end, and emits a
// read-aligned pixel stream with frame/border flags for the 3x3 window.
// Ports:
//   clk, rst_b          : pixel clock, asynchronous active-low reset
//   vvalid, hvalid      : frame valid and line/pixel valid from the sensor
//   wr_en, wr_bank      : registered write strobe and one-hot bank select
//   wr_addr, rd_addr    : registered column address (read = write column)
//   tap_sel             : index of the bank holding the newest line
//   hsync, fsync        : output pixel valid / first output pixel of frame
//   ini_row, ini_column : first output row / column 0 of an output row
//   col_cnt, row_cnt    : coordinates of the current output pixel
//   ovf_err             : sticky, a line exceeded 2^AW pixels
// ---------------------------------------------------------------------------
module line3_ctrl
  import canny_pkg::*;
#(
  parameter int AW = 10,
  parameter int RW = 11
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             vvalid,
  input  logic             hvalid,
  output logic             wr_en,
  output logic [NBANK-1:0] wr_bank,
  output logic [AW-1:0]    wr_addr,
  output logic [AW-1:0]    rd_addr,
  output logic [1:0]       tap_sel,
  output logic             hsync,
  output logic             fsync,
  output logic             ini_row,
  output logic             ini_column,
  output logic [AW-1:0]    col_cnt,
  output logic [RW-1:0]    row_cnt,
  output logic             ovf_err
);

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [RW-1:0] ROW_MAX  = '1;
  localparam logic [1:0]    FILL_END = 2'(FILL_LINES - 1);

  state_e          state_q, state_d;
  logic            vvalid_q, hvalid_q;
  logic [AW-1:0]   col_q, col_d;
  logic            line_ovf_q, line_ovf_d;
  logic [1:0]      lines_q, lines_d;
  logic [RW-1:0]   row_q, row_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            ovf_err_q, ovf_err_d;
  logic            s1_vld_q, s1_vld_d;
  logic [RW-1:0]   s1_row_q, s1_row_d;
  logic            hsync_q, hsync_d;
  logic            fsync_q, fsync_d;
  logic [AW-1:0]   col_cnt_q, col_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;

  logic            v_rise, v_fall, active, line_end;
  logic [AW-1:0]   col_base;
  logic            ovf_base;
  logic            rot_clear, rot_adv;

  // A rising edge of vvalid starts the frame in the same cycle, so the
  // column and overflow state seen by that cycle's pixel is the cleared one.
  assign v_rise   = vvalid & ~vvalid_q;
  assign v_fall   = ~vvalid & vvalid_q;
  assign active   = vvalid & ((state_q != IDLE) | v_rise);
  assign line_end = vvalid & (state_q != IDLE) & hvalid_q & ~hvalid;
  assign col_base = v_rise ? '0 : col_q;
  assign ovf_base = v_rise ? 1'b0 : line_ovf_q;

  // Sequencing and write side. Once a line has filled every RAM address the
  // address parks at the top, further pixels are dropped and flagged.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_ovf_d = line_ovf_q;
    lines_d    = lines_q;
    row_d      = row_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    ovf_err_d  = ovf_err_q;
    rot_clear  = 1'b0;
    rot_adv    = 1'b0;

    if (v_fall) begin
      state_d    = IDLE;
      col_d      = '0;
      line_ovf_d = 1'b0;
      lines_d    = '0;
      row_d      = '0;
      wr_addr_d  = '0;
    end else if (active) begin
      if (v_rise) begin
        state_d    = FILL;
        col_d      = '0;
        line_ovf_d = 1'b0;
        lines_d    = '0;
        row_d      = '0;
        wr_addr_d  = '0;
        ovf_err_d  = 1'b0;
        rot_clear  = 1'b1;
      end
      if (hvalid) begin
        if (ovf_base) begin
          wr_addr_d = ADDR_MAX;
          ovf_err_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = col_base;
          if (col_base == ADDR_MAX) begin
            line_ovf_d = 1'b1;
          end else begin
            col_d = col_base + 1'b1;
          end
        end
      end else if (line_end) begin
        col_d      = '0;
        line_ovf_d = 1'b0;
        wr_addr_d  = '0;
        rot_adv    = 1'b1;
        if (state_q == FILL) begin
          if (lines_q == FILL_END) begin
            state_d = RUN;
          end else begin
            lines_d = lines_q + 2'd1;
          end
        end else if (row_q != ROW_MAX) begin
          row_d = row_q + 1'b1;
        end
      end
    end
  end

  // Output side: one stage matches the write register, the second matches
  // the RAM read latency. col_cnt tracks wr_addr one cycle later, so it
  // always names the column whose data is on the RAM output.
  always_comb begin
    s1_vld_d  = wr_en_d & (state_q == RUN);
    s1_row_d  = row_q;
    hsync_d   = s1_vld_q;
    col_cnt_d = wr_addr_q;
    row_cnt_d = s1_row_q;
    fsync_d   = s1_vld_q & (wr_addr_q == '0) & (s1_row_q == '0);
  end

  // vvalid_q resets high so a frame already in progress at reset release
  // is skipped until vvalid is seen low and rises again.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      vvalid_q   <= 1'b1;
      hvalid_q   <= 1'b0;
      col_q      <= '0;
      line_ovf_q <= 1'b0;
      lines_q    <= '0;
      row_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      ovf_err_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_row_q   <= '0;
      hsync_q    <= 1'b0;
      fsync_q    <= 1'b0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      vvalid_q   <= vvalid;
      hvalid_q   <= hvalid;
      col_q      <= col_d;
      line_ovf_q <= line_ovf_d;
      lines_q    <= lines_d;
      row_q      <= row_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      ovf_err_q  <= ovf_err_d;
      s1_vld_q   <= s1_vld_d;
      s1_row_q   <= s1_row_d;
      hsync_q    <= hsync_d;
      fsync_q    <= fsync_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  lb_bank_rot u_bank_rot (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear   (rot_clear),
    .advance (rot_adv),
    .bank    (wr_bank),
    .tap_sel (tap_sel)
  );

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign rd_addr    = wr_addr_q;
  assign hsync      = hsync_q;
  assign fsync      = fsync_q;
  assign col_cnt    = col_cnt_q;
  assign row_cnt    = row_cnt_q;
  assign ovf_err    = ovf_err_q;
  assign ini_row    = (row_cnt_q == '0) & hsync_q;
  assign ini_column = (col_cnt_q == '0) & hsync_q;

endmodule

// File: tb/tb_line3_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line3_ctrl
// Scoreboard bench for line3_ctrl with AW=4 (16-pixel lines). The reference
// model thinks in frames, line indices and pixel indices; every accepted
// pixel pushes the expected RAM write and, once two lines are stored, the
// expected output pixel, each tagged with the cycle it must appear in.
// ---------------------------------------------------------------------------
module tb_line3_ctrl;
  import canny_pkg::*;

  localparam int AW    = 4;
  localparam int RW    = 11;
  localparam int DEPTH = 1 << AW;

  logic             clk    = 1'b0;
  logic             rst_b  = 1'b1;
  logic             vvalid = 1'b0;
  logic             hvalid = 1'b0;
  logic             wr_en;
  logic [NBANK-1:0] wr_bank;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [1:0]       tap_sel;
  logic             hsync;
  logic             fsync;
  logic             ini_row;
  logic             ini_column;
  logic [AW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             ovf_err;

  typedef struct {
    int due;
    int bank;
    int tap;
    int addr;
  } wr_ev_t;

  typedef struct {
    int due;
    int col;
    int row;
    int fs;
  } px_ev_t;

  wr_ev_t wq[$];
  px_ev_t pq[$];
  wr_ev_t mon_w;
  px_ev_t mon_p;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  // reference model state: frame open, line index in frame, pixel in line
  bit m_prev_v   = 1'b1;
  bit m_prev_h   = 1'b0;
  bit m_in_frame = 1'b0;
  bit m_ovf      = 1'b0;
  int m_line     = 0;
  int m_pix      = 0;

  line3_ctrl #(.AW(AW), .RW(RW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .vvalid     (vvalid),
    .hvalid     (hvalid),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .tap_sel    (tap_sel),
    .hsync      (hsync),
    .fsync      (fsync),
    .ini_row    (ini_row),
    .ini_column (ini_column),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt),
    .ovf_err    (ovf_err)
  );

  // free-running pixel clock
  initial forever #5 clk = ~clk;

  // safety net so a broken design can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // drive one sample cycle and let the model decide what it must cause
  task automatic applyStimulus(input bit v, input bit h);
    int s;
    bit rise;
    bit fall;
    @(negedge clk);
    vvalid = v;
    hvalid = h;
    s    = cyc + 1;
    rise = v && !m_prev_v;
    fall = !v && m_prev_v;
    if (fall) begin
      m_in_frame = 1'b0;
      m_line     = 0;
      m_pix      = 0;
    end else if (rise) begin
      m_in_frame = 1'b1;
      m_line     = 0;
      m_pix      = 0;
      m_ovf      = 1'b0;
    end
    if (m_in_frame && v) begin
      if (h) begin
        if (m_pix < DEPTH) begin
          wq.push_back('{due: s, bank: 1 << (m_line % 3), tap: m_line % 3, addr: m_pix});
          if (m_line >= FILL_LINES) begin
            pq.push_back('{due: s + 1, col: m_pix, row: m_line - FILL_LINES,
                           fs: (m_line == FILL_LINES && m_pix == 0) ? 1 : 0});
          end
        end else begin
          m_ovf = 1'b1;
        end
        m_pix++;
      end else if (m_prev_h && !rise) begin
        m_line++;
        m_pix = 0;
      end
    end
    m_prev_v = v;
    m_prev_h = h;
  endtask

  task automatic sendLine(input int npix, input int gap);
    for (int i = 0; i < npix; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < gap; i++) applyStimulus(1'b1, 1'b0);
  endtask

  // reset with the given inputs held; anything in flight is discarded
  task automatic doReset(input bit v, input bit h);
    @(negedge clk);
    rst_b  = 1'b0;
    vvalid = v;
    hvalid = h;
    wq.delete();
    pq.delete();
    repeat (3) @(negedge clk);
    rst_b      = 1'b1;
    m_prev_v   = 1'b1;
    m_prev_h   = 1'b0;
    m_in_frame = 1'b0;
    m_ovf      = 1'b0;
    m_line     = 0;
    m_pix      = 0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_wr_en",      int'(wr_en),      0);
    checkOutput("rst_wr_bank",    int'(wr_bank),    1);
    checkOutput("rst_wr_addr",    int'(wr_addr),    0);
    checkOutput("rst_rd_addr",    int'(rd_addr),    0);
    checkOutput("rst_tap_sel",    int'(tap_sel),    0);
    checkOutput("rst_hsync",      int'(hsync),      0);
    checkOutput("rst_fsync",      int'(fsync),      0);
    checkOutput("rst_ini_row",    int'(ini_row),    0);
    checkOutput("rst_ini_column", int'(ini_column), 0);
    checkOutput("rst_col_cnt",    int'(col_cnt),    0);
    checkOutput("rst_row_cnt",    int'(row_cnt),    0);
    checkOutput("rst_ovf_err",    int'(ovf_err),    0);
  endtask

  // Monitor: just after each edge, pop and compare whatever the DUT
  // presents, then flag any expected event whose cycle has passed unseen.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_en) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_err++;
        $display("[TB] FAIL wr_unexpected: got wr_en=1 addr=%0d bank=%b at cycle %0d, required no write",
                 wr_addr, wr_bank, cyc);
      end else begin
        mon_w = wq.pop_front();
        if (mon_w.due != cyc || int'(wr_bank) != mon_w.bank || int'(tap_sel) != mon_w.tap ||
            int'(wr_addr) != mon_w.addr || rd_addr != wr_addr) begin
          n_err++;
          $display("[TB] FAIL write: got cyc=%0d bank=%b tap=%0d addr=%0d rd=%0d, required cyc=%0d bank=%0d tap=%0d addr=%0d",
                   cyc, wr_bank, tap_sel, wr_addr, rd_addr, mon_w.due, mon_w.bank, mon_w.tap, mon_w.addr);
        end
      end
    end
    if (hsync) begin
      n_cmp++;
      if (pq.size() == 0) begin
        n_err++;
        $display("[TB] FAIL pix_unexpected: got hsync=1 col=%0d row=%0d at cycle %0d, required no output",
                 col_cnt, row_cnt, cyc);
      end else begin
        mon_p = pq.pop_front();
        if (mon_p.due != cyc || int'(col_cnt) != mon_p.col || int'(row_cnt) != mon_p.row ||
            int'(fsync) != mon_p.fs || int'(ini_row) != ((mon_p.row == 0) ? 1 : 0) ||
            int'(ini_column) != ((mon_p.col == 0) ? 1 : 0)) begin
          n_err++;
          $display("[TB] FAIL pixel: got cyc=%0d col=%0d row=%0d fs=%0d ir=%0d ic=%0d, required cyc=%0d col=%0d row=%0d fs=%0d",
                   cyc, col_cnt, row_cnt, fsync, ini_row, ini_column, mon_p.due, mon_p.col, mon_p.row, mon_p.fs);
        end
      end
    end
    if (!hsync && (fsync || ini_row || ini_column)) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL flags_no_hsync: got fsync=%0d ini_row=%0d ini_column=%0d at cycle %0d, required 0",
               fsync, ini_row, ini_column, cyc);
    end
    while (wq.size() != 0 && wq[0].due < cyc) begin
      mon_w = wq.pop_front();
      n_cmp++;
      n_err++;
      $display("[TB] FAIL wr_missing: got no write, required addr=%0d bank=%0d at cycle %0d",
               mon_w.addr, mon_w.bank, mon_w.due);
    end
    while (pq.size() != 0 && pq[0].due < cyc) begin
      mon_p = pq.pop_front();
      n_cmp++;
      n_err++;
      $display("[TB] FAIL pix_missing: got no hsync, required col=%0d row=%0d at cycle %0d",
               mon_p.col, mon_p.row, mon_p.due);
    end
  end

  // Directed scenarios first, then randomized frames, then a drain.
  initial begin
    int nl;
    int len;
    int abort_line;
    int n_idle;

    doReset(1'b0, 1'b0);
    checkResetState();

    $display("[TB] normal 5x16 frame with bank rotation");
    repeat (3) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int ln = 0; ln < 5; ln++) begin
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      @(posedge clk);
      #2;
      checkOutput("rot_wr_bank", int'(wr_bank), 1 << (m_line % 3));
      checkOutput("rot_tap_sel", int'(tap_sel), m_line % 3);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
    end
    repeat (3) applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("row_cnt_end", int'(row_cnt), 3);
    checkOutput("ovf_none", int'(ovf_err), 0);
    repeat (3) applyStimulus(1'b0, 1'b0);

    $display("[TB] overflow line, vvalid and hvalid rising together");
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("ovf_wr_en",   int'(wr_en),   0);
    checkOutput("ovf_wr_addr", int'(wr_addr), DEPTH - 1);
    checkOutput("ovf_set",     int'(ovf_err), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int ln = 0; ln < 3; ln++) sendLine(10, 2);
    checkOutput("ovf_sticky_frame", int'(ovf_err), 1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("ovf_sticky_idle", int'(ovf_err), 1);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("ovf_cleared", int'(ovf_err), 0);
    sendLine(8, 2);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] abort with vvalid and hvalid falling together");
    applyStimulus(1'b1, 1'b0);
    for (int ln = 0; ln < 4; ln++) sendLine(6, 2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("abort_no_rot_bank", int'(wr_bank), 2);
    checkOutput("abort_no_rot_tap",  int'(tap_sel), 1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("abort_row_clear", int'(row_cnt), 0);
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("restart_bank", int'(wr_bank), 1);
    checkOutput("restart_tap",  int'(tap_sel), 0);
    for (int ln = 0; ln < 3; ln++) sendLine(7, 2);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] spurious hvalid while vvalid is low");
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("spur_wr_addr", int'(wr_addr), 0);
    checkOutput("spur_col_cnt", int'(col_cnt), 0);
    checkOutput("spur_row_cnt", int'(row_cnt), 0);
    checkOutput("spur_wr_en",   int'(wr_en),   0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(1'b1, 1'b0);
    for (int ln = 0; ln < 3; ln++) sendLine(8, 2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    doReset(1'b1, 1'b1);
    checkResetState();
    for (int ln = 0; ln < 3; ln++) sendLine(8, 2);
    checkOutput("rst_frame_ignored", int'(row_cnt), 0);
    repeat (2) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int ln = 0; ln < 3; ln++) sendLine(5, 1);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      nl = int'($urandom_range(1, 6));
      abort_line = -1;
      if ($urandom_range(0, 2) == 0) abort_line = int'($urandom_range(0, nl - 1));
      applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      for (int ln = 0; ln < nl; ln++) begin
        len = int'($urandom_range(1, 20));
        if (ln == abort_line) begin
          for (int i = 0; i < int'($urandom_range(1, len)); i++) applyStimulus(1'b1, 1'b1);
          break;
        end
        sendLine(len, int'($urandom_range(1, 3)));
      end
      n_idle = int'($urandom_range(1, 3));
      for (int i = 0; i < n_idle; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      applyStimulus(1'b0, 1'b0);
    end

    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("wr_queue_drained",  wq.size(), 0);
    checkOutput("pix_queue_drained", pq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line3_ctrl.md
# line3_ctrl

Sequencing controller for the three-line buffer in the Canny front end. It sits between the sensor timing (`vvalid`/`hvalid`) and three single-port-write / single-port-read line RAMs, each 2^AW deep. It generates write/read addresses and rotates the write bank one-hot at each line end. It also tells the 3x3 window which bank holds the newest line, and emits pipeline-aligned `hsync`/`fsync` plus border flags (`ini_row`, `ini_column`) for downstream Sobel/NMS stages.

## Interface
- AW, 10, line-RAM address width; maximum line length 2^AW pixels
- RW, 11, row counter width
- clk  in  1  pixel clock (74.5 MHz)
- rst_b  in  1  asynchronous, active-low reset
- vvalid  in  1  frame valid from sensor
- hvalid  in  1  line/pixel valid from sensor
- wr_en  out  1  line-RAM write strobe
- wr_bank  out  3  one-hot bank select for the write
- wr_addr  out  AW  write address (column)
- rd_addr  out  AW  read address, same value as wr_addr (read of the two older banks)
- tap_sel  out  2  index 0..2 of the bank holding the newest line
- hsync  out  1  output pixel valid, aligned to RAM read data
- fsync  out  1  one-cycle pulse on the first output pixel of a frame
- ini_row  out  1  high for every pixel of the first output row
- ini_column  out  1  high on column 0 of each output row
- col_cnt  out  AW  column of the current output pixel
- row_cnt  out  RW  output row index
- ovf_err  out  1  sticky: line exceeded 2^AW pixels

## Operation
- State machine: IDLE, FILL, RUN.
- IDLE -> FILL on the vvalid rising edge. In the same cycle, counters clear, wr_bank=3'b001, tap_sel=0, and ovf_err clears.
- FILL: writes lines with no output. A line end is a falling edge of hvalid while vvalid=1. After 2 completed lines -> RUN.
- RUN: writes continue. Output is enabled: hsync follows hvalid with the latency given under Timing.
- Any state: vvalid falling -> IDLE. Counters clear. No rotation on that cycle, even if hvalid falls simultaneously.
- wr_en = hvalid & vvalid & (state != IDLE or vvalid rising this cycle) & ~line_ovf.
- wr_addr increments per written pixel and clears to 0 at each line end.
- At each line end, wr_bank rotates 001->010->100->001 and tap_sel advances 0->1->2->0.
- Overflow: if a line reaches 2^AW pixels, the address saturates at 2^AW-1, wr_en is suppressed for the rest of the line, and ovf_err is set. ovf_err holds until the next frame start.
- hvalid high while vvalid low is ignored: no writes and no counting.
- row_cnt increments at each RUN line end and saturates at 2^RW-1.
- ini_row = (row_cnt==0) & hsync.
- ini_column = (col_cnt==0) & hsync.

## Timing
- Reset value of every output is 0, except wr_bank=3'b001.
- Write outputs (wr_en, wr_bank, wr_addr, rd_addr) are registered. They are valid the cycle after the corresponding hvalid sample.
- RAM read latency is 1 cycle. hsync, fsync, ini_row, ini_column, col_cnt and row_cnt are delayed one further cycle so they align with RAM data.
- Total latency, hvalid in -> hsync out: 2 cycles.
- tap_sel changes on the same cycle wr_bank rotates. The window mux must delay its use of tap_sel by the same 1 cycle.
- fsync: exactly 1 pulse per frame, on the first RUN pixel.
- vvalid rising with hvalid already high: pixel 0 is written at addr 0 in that cycle.

## Structure
- Shared package `canny_pkg`:
  - state enum {IDLE, FILL, RUN}
  - NBANK=3
  - FILL_LINES=2
- Sub-module `lb_bank_rot`: one-hot rotator plus tap_sel counter. Inputs: clear, advance. It is the natural split; all other logic stays in line3_ctrl.

## Test plan
- **Reset and idle:** assert rst_b=0 mid-frame, then release. All outputs are 0, wr_bank=001, state IDLE, and no hsync until the next vvalid rising edge.
- **Normal 3-line fill:** frame of 5 lines x 16 pixels.
  - No hsync during lines 0-1.
  - hsync appears 2 cycles after line 2's first hvalid.
  - fsync pulses once, together with ini_row=1 and ini_column=1.
  - row_cnt ends at 3.
- **Bank rotation:** 4 lines. wr_bank sequence is 001,010,100,001 and tap_sel is 0,1,2,0, with each change on the cycle after a hvalid fall.
- **Overflow with AW=4:** an 18-pixel line.
  - wr_addr saturates at 15.
  - wr_en is low for the last 2 pixels.
  - ovf_err=1 and stays set until the next vvalid rising edge.
- **Abort:** vvalid falls on the same cycle as hvalid falls in RUN. State goes to IDLE and there is no bank rotation. The next frame restarts from wr_bank=001 and row_cnt=0.
- **Spurious hvalid:** hvalid toggles while vvalid=0. There are no writes and all counters stay at 0.
